// File: rtl/tmds_deserializer.sv
// -----------------------------------------------------------------------------
// tmds_deserializer
//
// Purpose:
//   Recovers 10-bit TMDS words from a single serial lane clocked at 10x the
//   pixel rate. Bits arrive LSB first. A free-running 0..9 bit counter marks
//   word boundaries. An alignment FSM (SEARCH / VERIFY / LOCKED) uses the four
//   TMDS control tokens to find the word phase. While searching, it moves the
//   boundary one bit later (a "slip") after too many token-free words.
//
// Ports:
//   x_clk       in   bit clock, rising edge only
//   rst         in   synchronous, active-high reset
//   serial_in   in   serial TMDS bit, already synchronous to x_clk
//   data_out    out  [9:0] last assembled word, bit 0 = first bit received
//   data_valid  out  one-cycle strobe: data_out / is_ctrl / ctrl were updated
//   is_ctrl     out  data_out is one of the four control tokens
//   ctrl        out  [1:0] decoded {c1,c0} when is_ctrl, else 2'b00
//   locked      out  high while the FSM is in LOCKED
//   slip        out  one-cycle pulse, coincident with data_valid, when a slip
//                    was taken at the preceding boundary
// -----------------------------------------------------------------------------
module tmds_deserializer #(
  parameter int unsigned CTRL_RUN     = 4,
  parameter int unsigned MISS_LIMIT   = 16,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic       x_clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic       slip
);

  // Each counter is just wide enough to hold its limit, so it never wraps.
  localparam int unsigned RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);
  localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  RUN_ZERO  = {RUN_W{1'b0}};
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN);
  localparam logic [MISS_W-1:0] MISS_ZERO = {MISS_W{1'b0}};
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);
  localparam logic [TMO_W-1:0]  TMO_ZERO  = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Returns {is_token, c1, c0} for a received word.
  function automatic logic [2:0] decode_token(input logic [9:0] w);
    logic [2:0] r;
    case (w)
      10'h354: r = 3'b100;
      10'h0AB: r = 3'b101;
      10'h154: r = 3'b110;
      10'h2AB: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // The conceptual 10-bit shift register drops its oldest bit before that bit
  // is ever used. The assembled word is always {serial_in, sr[9:1]}, so only
  // the nine most recent bits are stored. sr_q[8] holds the newest bit.
  logic [8:0]        sr_q,         sr_d;
  logic [3:0]        cnt_q,        cnt_d;
  logic              hold_q,       hold_d;
  state_t            state_q,      state_d;
  logic [RUN_W-1:0]  run_q,        run_d;
  logic [MISS_W-1:0] miss_q,       miss_d;
  logic [TMO_W-1:0]  tmo_q,        tmo_d;
  logic [9:0]        data_out_q,   data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              is_ctrl_q,    is_ctrl_d;
  logic [1:0]        ctrl_q,       ctrl_d;
  logic              locked_q,     locked_d;
  logic              slip_q,       slip_d;

  logic [9:0]       word;
  logic [2:0]       tok;
  logic             boundary;
  logic             take_slip;
  logic [RUN_W-1:0] run_next;

  // Word assembly, token decode and boundary detection.
  always_comb begin
    word     = {serial_in, sr_q};
    tok      = decode_token(word);
    boundary = (cnt_q == 4'd9);
    sr_d     = word[9:1];
  end

  // Alignment FSM: decisions are made only on the word captured at a boundary.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    miss_d    = miss_q;
    tmo_d     = tmo_q;
    take_slip = 1'b0;
    run_next  = run_q + RUN_ONE;
    if (boundary) begin
      case (state_q)
        ST_SEARCH: begin
          if (tok[2]) begin
            run_d  = RUN_ONE;
            miss_d = MISS_ZERO;
            tmo_d  = TMO_ZERO;
            // A run length of one already satisfies the lock condition.
            if (RUN_ONE == RUN_LAST) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_VERIFY;
            end
          end else if (miss_q == MISS_LAST) begin
            miss_d    = MISS_ZERO;
            take_slip = 1'b1;
          end else begin
            miss_d = miss_q + MISS_ONE;
          end
        end
        ST_VERIFY: begin
          if (tok[2]) begin
            run_d = run_next;
            if (run_next == RUN_LAST) begin
              state_d = ST_LOCKED;
              tmo_d   = TMO_ZERO;
            end else begin
              state_d = ST_VERIFY;
            end
          end else begin
            // A broken run restarts the search at the current phase.
            state_d = ST_SEARCH;
            run_d   = RUN_ZERO;
            miss_d  = MISS_ZERO;
          end
        end
        ST_LOCKED: begin
          if (tok[2]) begin
            tmo_d = TMO_ZERO;
          end else if (tmo_q == TMO_LAST) begin
            state_d = ST_SEARCH;
            run_d   = RUN_ZERO;
            miss_d  = MISS_ZERO;
            tmo_d   = TMO_ZERO;
          end else begin
            tmo_d = tmo_q + TMO_ONE;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          run_d   = RUN_ZERO;
          miss_d  = MISS_ZERO;
          tmo_d   = TMO_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Bit counter. A slip holds the counter at 0 for one extra cycle, so the
  // next word period is 11 cycles and the boundary moves one bit later.
  always_comb begin
    hold_d = 1'b0;
    if (hold_q) begin
      cnt_d = 4'd0;
    end else if (boundary) begin
      cnt_d  = 4'd0;
      hold_d = take_slip;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Output register next-state: words and strobes update only at boundaries.
  always_comb begin
    data_valid_d = boundary;
    slip_d       = take_slip;
    locked_d     = (state_d == ST_LOCKED);
    if (boundary) begin
      data_out_d = word;
      is_ctrl_d  = tok[2];
      ctrl_d     = tok[1:0];
    end else begin
      data_out_d = data_out_q;
      is_ctrl_d  = is_ctrl_q;
      ctrl_d     = ctrl_q;
    end
  end

  // All state and output flops, with synchronous reset.
  always_ff @(posedge x_clk) begin
    if (rst) begin
      sr_q         <= 9'd0;
      cnt_q        <= 4'd0;
      hold_q       <= 1'b0;
      state_q      <= ST_SEARCH;
      run_q        <= RUN_ZERO;
      miss_q       <= MISS_ZERO;
      tmo_q        <= TMO_ZERO;
      data_out_q   <= 10'd0;
      data_valid_q <= 1'b0;
      is_ctrl_q    <= 1'b0;
      ctrl_q       <= 2'b00;
      locked_q     <= 1'b0;
      slip_q       <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      state_q      <= state_d;
      run_q        <= run_d;
      miss_q       <= miss_d;
      tmo_q        <= tmo_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      is_ctrl_q    <= is_ctrl_d;
      ctrl_q       <= ctrl_d;
      locked_q     <= locked_d;
      slip_q       <= slip_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign is_ctrl    = is_ctrl_q;
  assign ctrl       = ctrl_q;
  assign locked     = locked_q;
  assign slip       = slip_q;

endmodule

// File: tb/tb_tmds_deserializer.sv
// -----------------------------------------------------------------------------
// tb_tmds_deserializer
//
// Scoreboard bench for tmds_deserializer. The stimulus pushes the expected
// word records for each scenario: the gap in cycles since the previous strobe
// or reset, the word, the token flags, locked and slip. It then drives the
// serial bits. The monitor runs on the falling edge and behaves as follows:
//   - When data_valid is high, it pops and compares one record.
//   - In reset cycles, it checks that all outputs are zero.
//   - In all other cycles, it checks that locked is steady and that slip and
//     data_valid are low.
// -----------------------------------------------------------------------------
module tb_tmds_deserializer;

  logic       x_clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b0;
  logic [9:0] data_out;
  logic       data_valid;
  logic       is_ctrl;
  logic [1:0] ctrl;
  logic       locked;
  logic       slip;

  tmds_deserializer #(
    .CTRL_RUN     (4),
    .MISS_LIMIT   (16),
    .LOCK_TIMEOUT (1024)
  ) dut (
    .x_clk      (x_clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .is_ctrl    (is_ctrl),
    .ctrl       (ctrl),
    .locked     (locked),
    .slip       (slip)
  );

  always #5 x_clk = ~x_clk;

  typedef struct {
    int         gap;
    logic [9:0] data;
    logic       isc;
    logic [1:0] ctl;
    logic       lk;
    logic       sl;
  } exp_t;

  exp_t sb[$];

  int   chk_n    = 0;
  int   err_n    = 0;
  int   edge_n   = 0;
  int   rst_edge = 0;
  logic rst_last = 1'b1;
  int   last_dv  = 0;
  logic hold_lk  = 1'b0;
  logic end_req  = 1'b0;
  exp_t cur;
  int   ref_e;
  int   gap_v;

  // Edge bookkeeping: count edges and remember the last edge that saw reset.
  always @(posedge x_clk) begin
    edge_n   <= edge_n + 1;
    rst_last <= rst;
    if (rst) rst_edge <= edge_n + 1;
  end

  // Monitor and scoreboard checker.
  always @(negedge x_clk) begin
    if (end_req) begin
      chk_n++;
      if (sb.size() != 0) begin
        err_n++;
        $display("FAIL drain: %0d records left, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
      $finish;
    end else if (rst_last === 1'b1) begin
      chk_n++;
      hold_lk = 1'b0;
      if ({data_out, data_valid, is_ctrl, ctrl, locked, slip} !== 16'h0000) begin
        err_n++;
        $display("FAIL reset_outs: data=%h dv=%b isc=%b ctrl=%b lk=%b slip=%b, required all 0",
                 data_out, data_valid, is_ctrl, ctrl, locked, slip);
      end
    end else if (data_valid === 1'b1) begin
      ref_e   = (last_dv > rst_edge) ? last_dv : rst_edge;
      gap_v   = edge_n - ref_e;
      last_dv = edge_n;
      chk_n++;
      if (sb.size() == 0) begin
        err_n++;
        $display("FAIL unexpected_valid: data=%h at edge %0d, required no strobe", data_out, edge_n);
      end else begin
        cur     = sb.pop_front();
        hold_lk = cur.lk;
        if (gap_v != cur.gap || data_out !== cur.data || is_ctrl !== cur.isc ||
            ctrl !== cur.ctl || locked !== cur.lk || slip !== cur.sl) begin
          err_n++;
          $display("FAIL word: gap=%0d data=%h isc=%b ctrl=%b lk=%b slip=%b, required gap=%0d data=%h isc=%b ctrl=%b lk=%b slip=%b",
                   gap_v, data_out, is_ctrl, ctrl, locked, slip,
                   cur.gap, cur.data, cur.isc, cur.ctl, cur.lk, cur.sl);
        end
      end
    end else begin
      chk_n++;
      if (locked !== hold_lk || slip !== 1'b0 || data_valid !== 1'b0) begin
        err_n++;
        $display("FAIL idle: lk=%b slip=%b dv=%b, required lk=%b slip=0 dv=0",
                 locked, slip, data_valid, hold_lk);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d records pending", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic b);
    serial_in = b;
    @(posedge x_clk);
    #1;
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) tick(w[i]);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick(1'($urandom));
    rst = 1'b0;
  endtask

  task automatic push(input int gap, input logic [9:0] d, input logic isc,
                      input logic [1:0] c, input logic lk, input logic sl);
    exp_t e;
    e.gap  = gap;
    e.data = d;
    e.isc  = isc;
    e.ctl  = c;
    e.lk   = lk;
    e.sl   = sl;
    sb.push_back(e);
  endtask

  initial begin
    // Reset with random input, then aligned 0x354 stream; lock on 4th word.
    do_reset(3);
    for (int k = 1; k <= 6; k++) push(10, 10'h354, 1'b1, 2'b00, (k >= 4) ? 1'b1 : 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) send_word(10'h354);

    // Reset in the middle of a word while locked, then relock.
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    do_reset(1);
    for (int k = 1; k <= 5; k++) push(10, 10'h354, 1'b1, 2'b00, (k >= 4) ? 1'b1 : 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) send_word(10'h354);

    // 0x2AB stream delayed by 3 bits. Three slips are needed, one every 16
    // words, and each takes an 11-cycle period.
    do_reset(2);
    push(10, 10'h158, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int k = 2; k <= 16; k++)  push(10, 10'h15D, 1'b0, 2'b00, 1'b0, (k == 16) ? 1'b1 : 1'b0);
    for (int k = 17; k <= 32; k++) push((k == 17) ? 11 : 10, 10'h2AE, 1'b0, 2'b00, 1'b0, (k == 32) ? 1'b1 : 1'b0);
    for (int k = 33; k <= 48; k++) push((k == 33) ? 11 : 10, 10'h157, 1'b0, 2'b00, 1'b0, (k == 48) ? 1'b1 : 1'b0);
    for (int k = 49; k <= 52; k++) push((k == 49) ? 11 : 10, 10'h2AB, 1'b1, 2'b11, (k == 52) ? 1'b1 : 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0);
    for (int k = 1; k <= 52; k++) send_word(10'h2AB);

    // Three 0x154, one non-token, four 0x154: lock only on the 7th token.
    do_reset(2);
    for (int k = 1; k <= 3; k++) push(10, 10'h154, 1'b1, 2'b10, 1'b0, 1'b0);
    push(10, 10'h1F0, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) push(10, 10'h154, 1'b1, 2'b10, (k == 4) ? 1'b1 : 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) send_word(10'h154);
    send_word(10'h1F0);
    for (int k = 1; k <= 4; k++) send_word(10'h154);

    // Lock timeout: 1023 misses survive, a token clears, 1024 misses drop lock.
    do_reset(2);
    for (int k = 1; k <= 4; k++) push(10, 10'h0AB, 1'b1, 2'b01, (k == 4) ? 1'b1 : 1'b0, 1'b0);
    for (int k = 1; k <= 1023; k++) push(10, 10'h1F0, 1'b0, 2'b00, 1'b1, 1'b0);
    push(10, 10'h0AB, 1'b1, 2'b01, 1'b1, 1'b0);
    for (int k = 1; k <= 1024; k++) push(10, 10'h1F0, 1'b0, 2'b00, (k == 1024) ? 1'b0 : 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) send_word(10'h0AB);
    for (int k = 1; k <= 1023; k++) send_word(10'h1F0);
    send_word(10'h0AB);
    for (int k = 1; k <= 1024; k++) send_word(10'h1F0);

    do_reset(2);
    end_req = 1'b1;
  end

endmodule
